// File: rtl/axi_burst_master_pkg.sv
// Shared encodings and FSM states for the cache-line AXI burst master.
// Imported by the burst master top.
package axi_burst_master_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_8B    = 3'd3;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_e;

endpackage

// File: rtl/axi_burst_master.sv
// One cache-line refill or write-back as a single AXI INCR burst.
// One transaction at a time; valids hold until their handshake.
module axi_burst_master
    import axi_burst_master_pkg::*;
#(
    parameter int unsigned BEATS  = 4,
    parameter int unsigned LINE_W = 64 * BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [31:0]       req_addr,
    input  logic [LINE_W-1:0] req_wline,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [LINE_W-1:0] resp_rline,
    output logic [31:0]       araddr,
    output logic              arvalid,
    output logic [1:0]        arburst,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    input  logic              arready,
    input  logic [63:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    input  logic              rlast,
    output logic              rready,
    output logic [31:0]       awaddr,
    output logic              awvalid,
    output logic [1:0]        awburst,
    output logic [7:0]        awlen,
    input  logic              awready,
    output logic [63:0]       wdata,
    output logic              wlast,
    output logic [7:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    localparam int unsigned   CW    = $clog2(BEATS);
    localparam int unsigned   OFS   = $clog2(8 * BEATS);
    localparam logic [CW-1:0] LAST  = CW'(BEATS - 1);
    localparam logic [31:0]   AMASK = ~((32'd1 << OFS) - 32'd1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic [LINE_W-1:0]   rline_q, rline_d;
    logic                err_q, err_d;

    assign arburst    = BURST_INCR;
    assign awburst    = BURST_INCR;
    assign arsize     = SIZE_8B;
    assign arlen      = 8'(BEATS - 1);
    assign awlen      = 8'(BEATS - 1);
    assign wstrb      = 8'hFF;
    assign araddr     = addr_q;
    assign awaddr     = addr_q;
    assign resp_rline = rline_q;
    assign wdata      = wline_q[int'(cnt_q) * 64 +: 64];

    // Next-state, datapath updates and handshake outputs per state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wline_d    = wline_q;
        rline_d    = rline_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr & AMASK;
                    wline_d = req_wline;
                    err_d   = 1'b0;
                    state_d = req_wen ? S_AW : S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    cnt_d   = '0;
                    state_d = S_R;
                end
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    rline_d[int'(cnt_q) * 64 +: 64] = rdata;
                    if (rresp != RESP_OKAY) err_d = 1'b1;
                    if (rlast || cnt_q == LAST) begin
                        // rlast must coincide exactly with the final beat
                        if (rlast != (cnt_q == LAST)) err_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    cnt_d   = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                wvalid = 1'b1;
                wlast  = (cnt_q == LAST);
                if (wready) begin
                    if (cnt_q == LAST) state_d = S_B;
                    else cnt_d = cnt_q + 1'b1;
                end
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    if (bresp != RESP_OKAY) err_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, refill line and error flag; cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rline_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rline_q <= rline_d;
            err_q   <= err_d;
        end
    end

    // Request payload captured at acceptance; no reset needed.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wline_q <= wline_d;
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master (BEATS = 4).
// The bench plays the AXI responder and checks against hand values.
module tb_axi_burst_master;

    localparam int BEATS = 4;
    localparam int LW    = 64 * BEATS;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_wen;
    logic [31:0]   req_addr;
    logic [LW-1:0] req_wline;
    logic          resp_valid, resp_err;
    logic [LW-1:0] resp_rline;
    logic [31:0]   araddr, awaddr;
    logic          arvalid, arready, rvalid, rlast, rready;
    logic [1:0]    arburst, awburst, rresp, bresp;
    logic [7:0]    arlen, awlen, wstrb;
    logic [2:0]    arsize;
    logic [63:0]   rdata, wdata;
    logic          awvalid, awready, wlast, wvalid, wready;
    logic          bvalid, bready;

    int checks = 0;
    int errors = 0;

    axi_burst_master #(.BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr),
        .req_wline(req_wline),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rline(resp_rline),
        .araddr(araddr), .arvalid(arvalid),
        .arburst(arburst), .arlen(arlen),
        .arsize(arsize), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .rlast(rlast), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid),
        .awburst(awburst), .awlen(awlen),
        .awready(awready),
        .wdata(wdata), .wlast(wlast), .wstrb(wstrb),
        .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] got,
                         input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic refill(input logic [31:0] addr, input int ar_wait,
                          input int r_gap, input int bad, input int last,
                          input logic [LW-1:0] line, input logic exp_err,
                          input int exp_lat, input logic chk_line);
        int cyc;
        logic [31:0] ea;
        ea = addr & 32'hFFFF_FFE0;
        check("rd_req_ready", req_ready, 1);
        req_valid = 1; req_wen = 0; req_addr = addr;
        step();
        req_valid = 0; req_addr = '0; cyc = 1;
        for (int i = 0; i < ar_wait; i++) begin
            check("ar_hold_valid", arvalid, 1);
            check("ar_hold_addr", araddr, ea);
            check("rd_busy", req_ready, 0);
            step(); cyc++;
        end
        check("arvalid", arvalid, 1);
        check("araddr", araddr, ea);
        check("arlen", arlen, 3);
        check("arburst", arburst, 1);
        check("arsize", arsize, 3);
        arready = 1;
        step(); cyc++;
        arready = 0;
        for (int b = 0; b <= last; b++) begin
            for (int g = 0; g < r_gap; g++) begin
                check("r_gap_rready", rready, 1);
                check("r_gap_busy", req_ready, 0);
                step(); cyc++;
            end
            check("rready", rready, 1);
            rvalid = 1;
            rdata  = line[b*64 +: 64];
            rresp  = (b == bad) ? 2'b10 : 2'b00;
            rlast  = (b == last);
            step(); cyc++;
            rvalid = 0; rlast = 0; rresp = 0;
        end
        for (int k = 0; k < 4 && !resp_valid; k++) begin
            step(); cyc++;
        end
        check("rd_resp_valid", resp_valid, 1);
        check("rd_resp_err", resp_err, exp_err);
        check("rd_latency", cyc, exp_lat);
        if (chk_line) check("rd_line", resp_rline, line);
        step();
        check("rd_pulse_end", resp_valid, 0);
        check("rd_idle", req_ready, 1);
    endtask

    task automatic wback(input logic [31:0] addr, input logic [LW-1:0] line,
                         input logic stall, input logic [1:0] br,
                         input logic exp_err, input int exp_lat,
                         input logic [LW-1:0] keep);
        int cyc;
        int b;
        logic phase;
        b = 0; phase = 0;
        check("wb_req_ready", req_ready, 1);
        req_valid = 1; req_wen = 1; req_addr = addr; req_wline = line;
        step();
        req_valid = 0; req_wen = 0; req_wline = '0; cyc = 1;
        check("awvalid", awvalid, 1);
        check("awaddr", awaddr, addr & 32'hFFFF_FFE0);
        check("awlen", awlen, 3);
        check("awburst", awburst, 1);
        check("w_before_aw", wvalid, 0);
        awready = 1;
        step(); cyc++;
        awready = 0;
        for (int k = 0; k < 40 && b < BEATS; k++) begin
            check("wvalid", wvalid, 1);
            check("wdata", wdata, line[b*64 +: 64]);
            check("wlast", wlast, b == BEATS - 1);
            check("wstrb", wstrb, 8'hFF);
            wready = stall ? phase : 1'b1;
            phase  = ~phase;
            step(); cyc++;
            if (wready) b++;
            wready = 0;
        end
        check("w_beats", b, BEATS);
        check("wvalid_drop", wvalid, 0);
        check("bready", bready, 1);
        bvalid = 1; bresp = br;
        step(); cyc++;
        bvalid = 0; bresp = 0;
        check("wb_resp_valid", resp_valid, 1);
        check("wb_resp_err", resp_err, exp_err);
        check("wb_latency", cyc, exp_lat);
        check("wb_rline_kept", resp_rline, keep);
        step();
        check("wb_pulse_end", resp_valid, 0);
    endtask

    logic [LW-1:0] la, lb, lc, ld, le, lw;

    initial begin
        la = {64'h44, 64'h33, 64'h22, 64'h11};
        lb = {64'hB3B3, 64'hB2B2, 64'hB1B1, 64'hB0B0};
        lc = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
        ld = {64'hD3D3, 64'hD2D2, 64'hD1D1, 64'hD0D0};
        le = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
        lw = {64'hDDDD_0003, 64'hDDDD_0002, 64'hDDDD_0001, 64'hDDDD_0000};
        rst = 1; req_valid = 0; req_wen = 0; req_addr = '0;
        req_wline = '0; arready = 0; rdata = '0; rresp = 0;
        rvalid = 0; rlast = 0; awready = 0; wready = 0;
        bresp = 0; bvalid = 0;
        step(); step();
        check("rst_req_ready", req_ready, 1);
        check("rst_valids",
              {arvalid, rready, awvalid, wvalid, wlast, bready}, 0);
        check("rst_resp", {resp_valid, resp_err}, 0);
        check("rst_rline", resp_rline, 0);
        rst = 0;
        step();

        refill(32'h8000_0013, 0, 0, -1, 3, la, 0, 6, 1);
        wback(32'h8000_0040, lw, 1, 2'b00, 0, 11, la);
        refill(32'h1234_5678, 5, 2, -1, 3, lb, 0, 19, 1);
        refill(32'h0000_0100, 0, 0, 2, 3, lc, 1, 6, 1);
        refill(32'h0000_0200, 0, 0, -1, 1, ld, 1, 4, 0);
        wback(32'h0000_0300, lw, 0, 2'b10, 1, 7,
              {lc[255:128], ld[127:0]});

        req_valid = 1; req_wen = 1; req_addr = 32'h40; req_wline = lw;
        step();
        req_valid = 0; req_wen = 0;
        awready = 1; step(); awready = 0;
        wready = 1; step(); step(); wready = 0;
        check("pre_rst_wvalid", wvalid, 1);
        check("pre_rst_wdata", wdata, lw[191:128]);
        rst = 1;
        #1;
        check("async_rst_valids",
              {arvalid, rready, awvalid, wvalid, wlast, bready}, 0);
        check("async_rst_resp", {resp_valid, resp_err}, 0);
        check("async_rst_rline", resp_rline, 0);
        @(negedge clk);
        rst = 0;
        step();
        check("post_rst_ready", req_ready, 1);
        check("post_rst_wvalid", wvalid, 0);
        refill(32'h8000_1008, 0, 0, -1, 3, le, 0, 6, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
